ofm_stream_reader: RTL and testbench
====================================

OFM_STREAM_READER -- requirements
Module: ofm_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, input pixel width; each OFM word is DATA_WIDTH*2 bits, signed.
REQ-002 SHALL have parameter OFM_SIZE, default 416, OFM height and width in words.
REQ-003 SHALL have parameter NO_FILTER, default 16, number of OFM channels.
REQ-004 SHALL have parameter ADDR_WIDTH, default 22, OFM memory address width; must satisfy 2^ADDR_WIDTH >= OFM_SIZE*OFM_SIZE*NO_FILTER.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, single-cycle pulse that begins a readout.
REQ-008 SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-009 SHALL have port done, output, 1, one-cycle pulse after the last beat is accepted.
REQ-010 SHALL have port mem_rd_en, output, 1, OFM DPRAM read-port enable.
REQ-011 SHALL have port mem_rd_addr, output, ADDR_WIDTH, OFM DPRAM read address.
REQ-012 SHALL have port mem_rd_data, input, DATA_WIDTH*2, read data, valid exactly 1 cycle after mem_rd_en.
REQ-013 SHALL have ports m_valid (output, 1), m_ready (input, 1) and m_data (output, DATA_WIDTH*2), forming the output stream.
REQ-014 SHALL have ports m_last_col, m_last_row and m_last (outputs, 1 each), marking the end of a row, the end of a channel, and the final word.

Function
REQ-015 SHALL use FSM states IDLE, READ, DRAIN and FINISH; IDLE->READ on start, READ->DRAIN after the last address is issued, DRAIN->FINISH when the last beat is accepted, FINISH->IDLE after exactly 1 cycle, with done=1 in FINISH.
REQ-016 SHALL ignore start in every state except IDLE.
REQ-017 SHALL issue addresses 0 .. OFM_SIZE*OFM_SIZE*NO_FILTER-1 in increasing order: channel-major, then row, then column (address = (ch*OFM_SIZE+row)*OFM_SIZE+col).
REQ-018 SHALL hold a 2-entry output buffer and assert mem_rd_en only when buffer occupancy plus in-flight reads is less than 2, so data is never lost or duplicated under any m_ready pattern.
REQ-019 SHALL sustain one beat per cycle while m_ready is held high, with first m_valid exactly 2 cycles after start is sampled.
REQ-020 SHALL hold m_data and all last flags stable while m_valid=1 and m_ready=0.
REQ-021 SHALL set m_last_col when col=OFM_SIZE-1, m_last_row when row=OFM_SIZE-1 and col=OFM_SIZE-1, and m_last on the final word only; the flags are carried alongside the data through the buffer.
REQ-022 SHALL maintain row, column and channel counters that wrap to 0 at OFM_SIZE-1, OFM_SIZE-1 and NO_FILTER-1 respectively, with no multiplier in the address path.

Reset
REQ-023 SHALL, while rst_n=0, force state=IDLE, buffer empty, all counters 0, and busy, done, mem_rd_en, mem_rd_addr, m_valid, m_data and all last flags to 0.
REQ-024 SHALL abort a transfer on a reset mid-operation with no done pulse; a subsequent start SHALL restart from address 0.

Configuration
REQ-025 SHALL, when macro OFM_READER_RELU_EN is defined, output 0 for any word whose sign bit is 1 and pass all other words unchanged; without the macro, m_data SHALL equal the memory word bit-exactly. Latency is the same in both cases.

Structure
REQ-026 SHALL take DATA_WIDTH defaults, the state encoding typedef and the OFM-size localparams from the shared accelerator package.
REQ-027 SHALL implement the 2-entry buffer as sub-module ofm_skid_fifo, with the FSM and counters in the parent.

Verification
REQ-028 SHALL cover: with OFM_SIZE=4, NO_FILTER=2, mem[a]=a and m_ready=1, start -> 32 beats with data 0..31 on consecutive cycles, m_last_col at 3,7,..., m_last_row at 15 and 31, m_last at 31, done 1 cycle after beat 31.
REQ-029 SHALL cover: the same setup with m_ready toggling 1010... -> identical data sequence, no gaps in data, and m_data stable during every stall.
REQ-030 SHALL cover: m_ready=0 for 20 cycles after start -> at most 2 reads outstanding, then 0..31 in order once m_ready=1.
REQ-031 SHALL cover: rst_n pulsed low at beat 10, then restart -> outputs 0 during reset, no done pulse, second run delivers 0..31.
REQ-032 SHALL cover: a second start pulse at beat 5 -> ignored, exactly 32 beats and one done pulse.
REQ-033 SHALL cover: OFM_READER_RELU_EN defined with mem[5]=16'hFFF3 -> beat 5 data 0; without the macro -> beat 5 data 16'hFFF3.

Source files
------------

// File: rtl/ofm_stream_reader_pkg.sv
// Shared accelerator definitions for the OFM readout path:
// default geometry, readout FSM encoding and a counter-sizing helper.
package ofm_stream_reader_pkg;

    localparam int unsigned OFM_DATA_WIDTH = 8;
    localparam int unsigned OFM_SIZE_DEF   = 416;
    localparam int unsigned OFM_NO_FILTER  = 16;
    localparam int unsigned OFM_ADDR_WIDTH = 22;
    localparam int unsigned OFM_BUF_DEPTH  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } ofm_state_t;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ofm_stream_reader_skid_fifo.sv
// Two-entry output buffer for the OFM stream; the entry carries the word and its
// last flags. The head is held until popped, so the output is stable during stalls.
module ofm_skid_fifo #(
    parameter int unsigned WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    output logic [1:0]       level
);

    logic [WIDTH-1:0] slot [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                slot[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                slot[wr_ptr] <= push_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    assign pop_data = slot[rd_ptr];
    assign valid    = (count != 2'd0);
    assign level    = count;

endmodule

// File: rtl/ofm_stream_reader.sv
// Streams a whole OFM (channel-major, row, column) out of the OFM DPRAM.
// Optional macro OFM_READER_RELU_EN clamps negative words to zero on the way in.
module ofm_stream_reader
    import ofm_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = OFM_DATA_WIDTH,
    parameter int unsigned OFM_SIZE   = OFM_SIZE_DEF,
    parameter int unsigned NO_FILTER  = OFM_NO_FILTER,
    parameter int unsigned ADDR_WIDTH = OFM_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [DATA_WIDTH*2-1:0] mem_rd_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH*2-1:0] m_data,
    output logic                    m_last_col,
    output logic                    m_last_row,
    output logic                    m_last
);

    localparam int unsigned WORD_W = DATA_WIDTH * 2;
    localparam int unsigned POS_W  = cnt_width(OFM_SIZE);
    localparam int unsigned CH_W   = cnt_width(NO_FILTER);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(OFM_SIZE - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NO_FILTER - 1);

    ofm_state_t state, state_nxt;

    logic [POS_W-1:0]      col;
    logic [POS_W-1:0]      row;
    logic [CH_W-1:0]       ch;
    logic [ADDR_WIDTH-1:0] addr;

    logic                  issue;
    logic                  room;
    logic                  pop;
    logic                  issue_col_end;
    logic                  issue_row_end;
    logic                  issue_last;
    logic                  rd_pend;
    logic [2:0]            rd_flags;
    logic [1:0]            fifo_level;
    logic [WORD_W-1:0]     wr_word;
    logic [WORD_W+2:0]     head;

    assign pop           = m_valid && m_ready;
    assign issue_col_end = (col == POS_LAST);
    assign issue_row_end = issue_col_end && (row == POS_LAST);
    assign issue_last    = issue_row_end && (ch == CH_LAST);

    // Slots still free after this cycle's pop, counting the read already in flight.
    assign room = ({1'b0, fifo_level} + {2'b00, rd_pend} - {2'b00, pop}) < 3'(OFM_BUF_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (room) begin
                    issue = 1'b1;
                    if (issue_last) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Linear address runs beside the nested counters, so no multiply is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            row  <= '0;
            ch   <= '0;
            addr <= '0;
        end else if ((state == IDLE) && start) begin
            col  <= '0;
            row  <= '0;
            ch   <= '0;
            addr <= '0;
        end else if (issue) begin
            addr <= issue_last ? '0 : addr + ADDR_WIDTH'(1);
            if (issue_col_end) begin
                col <= '0;
                if (issue_row_end) begin
                    row <= '0;
                    ch  <= (ch == CH_LAST) ? '0 : ch + CH_W'(1);
                end else begin
                    row <= row + POS_W'(1);
                end
            end else begin
                col <= col + POS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend  <= 1'b0;
            rd_flags <= '0;
        end else begin
            rd_pend  <= issue;
            rd_flags <= {issue_last, issue_row_end, issue_col_end};
        end
    end

    assign mem_rd_en   = issue;
    assign mem_rd_addr = addr;

`ifdef OFM_READER_RELU_EN
    assign wr_word = mem_rd_data[WORD_W-1] ? '0 : mem_rd_data;
`else
    assign wr_word = mem_rd_data;
`endif

    ofm_skid_fifo #(
        .WIDTH(WORD_W + 3)
    ) u_skid_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rd_pend),
        .push_data({rd_flags, wr_word}),
        .pop      (pop),
        .pop_data (head),
        .valid    (m_valid),
        .level    (fifo_level)
    );

    assign {m_last, m_last_row, m_last_col, m_data} = head;

endmodule

// File: tb/tb_ofm_stream_reader.sv
// Directed bench for ofm_stream_reader on a 4x4x2 OFM with mem[a]=a.
module tb_ofm_stream_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned OS = 4;
    localparam int unsigned NF = 2;
    localparam int unsigned AW = 5;
    localparam int unsigned WW = 16;
    localparam int          N  = 32;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic          m_ready = 1'b0;
    logic          busy, done, mem_rd_en, m_valid, m_last_col, m_last_row, m_last;
    logic [AW-1:0] mem_rd_addr;
    logic [WW-1:0] mem_rd_data = '0;
    logic [WW-1:0] m_data;
    logic [WW-1:0] mem [N];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [18:0]   beat_q [$];
    int            beat_cyc [$];
    int            cyc = 0;
    int            start_cyc = -1;
    int            done_cyc = -1;
    int            done_cnt = 0;
    int            issued = 0;
    int            accepted = 0;
    int            max_out = 0;
    int            gaps = 0;
    logic [AW-1:0] exp_addr = '0;
    logic          stall_prev = 1'b0;
    logic [18:0]   held = '0;

    always #5 clk = ~clk;

    ofm_stream_reader #(
        .DATA_WIDTH(DW),
        .OFM_SIZE  (OS),
        .NO_FILTER (NF),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last_col (m_last_col),
        .m_last_row (m_last_row),
        .m_last     (m_last)
    );

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return 32'({busy, done, mem_rd_en, mem_rd_addr, m_valid, m_data, m_last_col, m_last_row, m_last});
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (start && !busy) start_cyc = cyc;
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (mem_rd_en) begin
                check("rd_addr", 32'(mem_rd_addr), 32'(exp_addr));
                exp_addr++;
                issued++;
            end
            if (stall_prev)
                check("stall_hold", 32'({m_valid, m_last, m_last_row, m_last_col, m_data}), 32'({1'b1, held}));
            stall_prev = m_valid && !m_ready;
            held = {m_last, m_last_row, m_last_col, m_data};
            if (m_ready && !m_valid && accepted > 0 && accepted < N) gaps++;
            if (m_valid && m_ready) begin
                beat_q.push_back(held);
                beat_cyc.push_back(cyc);
                accepted++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tracking();
        beat_q.delete();
        beat_cyc.delete();
        start_cyc = -1;
        done_cyc  = -1;
        done_cnt  = 0;
        issued    = 0;
        accepted  = 0;
        max_out   = 0;
        gaps      = 0;
        exp_addr  = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: ready high, 1: ready toggling 1010..., 2: ready low for 20 cycles then high
    task automatic run_until_done(input int mode);
        int k = 0;
        while (done_cnt == 0 && k < 400) begin
            if (mode == 2 && k == 20) check("stall_reads", 32'(issued), 32'd2);
            case (mode)
                1:       m_ready = (k % 2 == 0);
                2:       m_ready = (k >= 20);
                default: m_ready = 1'b1;
            endcase
            tick();
            k++;
        end
        check("done_in_time", 32'(done_cnt > 0), 32'd1);
        m_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic verify_run(input logic [15:0] exp5, input bit timed);
        logic [18:0] e;
        check("beat_count", 32'(beat_q.size()), 32'(N));
        for (int i = 0; i < beat_q.size() && i < N; i++) begin
            e = {i == N - 1, i % 16 == 15, i % 4 == 3, 16'(i)};
            if (i == 5) e[15:0] = exp5;
            check($sformatf("beat%0d", i), 32'(beat_q[i]), 32'(e));
            if (timed) check($sformatf("beat%0d_cyc", i), 32'(beat_cyc[i]), 32'(start_cyc + 3 + i));
        end
        if (timed) check("done_cyc", 32'(done_cyc), 32'(start_cyc + 3 + N));
        check("max_outstanding", 32'(max_out), 32'd2);
        check("gaps", 32'(gaps), 32'd0);
        check("done_cnt", 32'(done_cnt), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        for (int a = 0; a < N; a++) mem[a] = 16'(a);
        clear_tracking();
        tick();
        tick();
        check("reset_outs", outs_vec(), 32'd0);
        rst_n = 1'b1;
        tick();

        // full-rate readout
        m_ready = 1'b1;
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        run_until_done(0);
        verify_run(16'd5, 1'b1);

        // ready toggling
        clear_tracking();
        pulse_start();
        run_until_done(1);
        verify_run(16'd5, 1'b0);

        // long initial stall
        clear_tracking();
        m_ready = 1'b0;
        pulse_start();
        run_until_done(2);
        verify_run(16'd5, 1'b0);

        // reset at beat 10, then restart
        clear_tracking();
        m_ready = 1'b1;
        pulse_start();
        k = 0;
        while (accepted < 10 && k < 100) begin
            tick();
            k++;
        end
        check("reach_beat10", 32'(accepted >= 10), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", outs_vec(), 32'd0);
        repeat (3) tick();
        check("rst_hold_outs", outs_vec(), 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        clear_tracking();
        pulse_start();
        run_until_done(0);
        verify_run(16'd5, 1'b1);

        // second start at beat 5 is ignored
        clear_tracking();
        pulse_start();
        k = 0;
        while (accepted < 5 && k < 100) begin
            tick();
            k++;
        end
        check("reach_beat5", 32'(accepted >= 5), 32'd1);
        pulse_start();
        run_until_done(0);
        verify_run(16'd5, 1'b1);

        // negative word at address 5
        mem[5] = 16'hFFF3;
        clear_tracking();
        pulse_start();
        run_until_done(0);
`ifdef OFM_READER_RELU_EN
        verify_run(16'h0000, 1'b1);
`else
        verify_run(16'hFFF3, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
